// File: rtl/iterative_muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit: shift-add multiplier and restoring
// divider sharing one 2*XLEN accumulator, one bit per clock.
module iterative_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state, state_nxt;
  logic [2:0]        op, op_nxt;
  logic [XLEN-1:0]   divisor, divisor_nxt;
  logic [2*XLEN-1:0] acc, acc_nxt;
  logic              neg, neg_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [XLEN-1:0]   result_q, result_nxt;

  logic            is_div, a_signed, b_signed, a_neg, b_neg, special;
  logic [XLEN-1:0] a_mag, b_mag, special_res;

  // Operand conditioning at acceptance; MUL is sign-agnostic so it runs unsigned.
  assign is_div   = funct3[2];
  assign a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                    (funct3 == 3'b100) || (funct3 == 3'b110);
  assign b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
  assign a_neg    = a_signed & a[XLEN-1];
  assign b_neg    = b_signed & b[XLEN-1];
  assign a_mag    = a_neg ? -a : a;
  assign b_mag    = b_neg ? -b : b;

  assign special = is_div && ((b == '0) ||
                   (!funct3[0] && (a == MIN_INT) && (b == '1)));
  assign special_res = (b == '0) ? (funct3[1] ? a : '1)
                                 : (funct3[1] ? '0 : a);

  logic [XLEN:0]     mul_sum, shifted, diff;
  logic [2*XLEN-1:0] mul_step, div_step, step, prod_fix;
  logic [XLEN-1:0]   quo, rem, final_res;

  // Divide keeps {remainder, dividend/quotient} in acc; multiply keeps {partial, multiplier}.
  assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, divisor} : '0);
  assign mul_step = {mul_sum, acc[XLEN-1:1]};
  assign shifted  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
  assign diff     = shifted - {1'b0, divisor};
  assign div_step = diff[XLEN] ? {shifted[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                               : {diff[XLEN-1:0],    acc[XLEN-2:0], 1'b1};
  assign step     = op[2] ? div_step : mul_step;
  assign prod_fix = neg ? -step : step;
  assign quo      = step[XLEN-1:0];
  assign rem      = step[2*XLEN-1:XLEN];

  always_comb begin
    final_res = '0;
    case (op)
      3'b000:                 final_res = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: final_res = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         final_res = neg ? -quo : quo;
      default:                final_res = neg ? -rem : rem;
    endcase
  end

  always_comb begin
    state_nxt   = state;
    op_nxt      = op;
    divisor_nxt = divisor;
    acc_nxt     = acc;
    neg_nxt     = neg;
    cnt_nxt     = cnt;
    result_nxt  = result_q;
    case (state)
      IDLE, DONE: begin
        if (state == DONE) state_nxt = IDLE;
        if (start) begin
          op_nxt      = funct3;
          divisor_nxt = b_mag;
          acc_nxt     = {{XLEN{1'b0}}, a_mag};
          neg_nxt     = (is_div && funct3[1]) ? a_neg : (a_neg ^ b_neg);
          cnt_nxt     = '0;
          if (special) begin
            result_nxt = special_res;
            state_nxt  = DONE;
          end else begin
            state_nxt = CALC;
          end
        end
      end
      CALC: begin
        acc_nxt = step;
        cnt_nxt = cnt + 1'b1;
        if (cnt == LAST) begin
          result_nxt = final_res;
          state_nxt  = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      op       <= '0;
      divisor  <= '0;
      acc      <= '0;
      neg      <= 1'b0;
      cnt      <= '0;
      result_q <= '0;
    end else begin
      state    <= state_nxt;
      op       <= op_nxt;
      divisor  <= divisor_nxt;
      acc      <= acc_nxt;
      neg      <= neg_nxt;
      cnt      <= cnt_nxt;
      result_q <= result_nxt;
    end
  end

  assign busy   = (state == CALC);
  assign done   = (state == DONE);
  assign result = result_q;

endmodule
